// File: rtl/mux_4x1_8bits_pkg.sv
`default_nettype none
// ============================================================================
// mux_4x1_8bits_pkg : lane constants, FSM encoding and lane-mask helpers
// Revision 1.0
// ============================================================================
package mux_4x1_8bits_pkg;

  localparam int LANES  = 4;
  localparam int MASK_W = LANES;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef logic [MASK_W-1:0] mask_t;
  typedef logic [LANE_W-1:0] lane_t;

  function automatic lane_t lowest_lane(input mask_t m);
    lane_t r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) r = lane_t'(i);
    end
    return r;
  endfunction

  function automatic mask_t clear_lowest(input mask_t m);
    return m & (m - mask_t'(1));
  endfunction

  function automatic logic is_last(input mask_t m);
    return (m != '0) && (clear_lowest(m) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_word_buffer.sv
`default_nettype none
// ============================================================================
// mux_word_buffer : two-slot ACTIVE/PENDING word store with ready generation
// Revision 1.0
// ============================================================================
module mux_word_buffer
  import mux_4x1_8bits_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                fire_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    word_i,
  input  mask_t                               mask_i,
  input  logic                                emit_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    act_data_o,
  output mask_t                               act_mask_o,
  output logic                                pend_full_o,
  output logic                                ready_o
);

  logic [LANES-1:0][DATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  mask_t                            act_mask_q, act_mask_d;
  mask_t                            pend_mask_q, pend_mask_d;
  mask_t                            w_act_rem;
  logic                             w_act_free;
  logic                             w_pend_full;

  // A non-zero mask marks a slot as occupied.
  assign w_pend_full = |pend_mask_q;
  assign w_act_rem   = clear_lowest(act_mask_q);
  assign w_act_free  = (act_mask_q == '0) || (emit_i && (w_act_rem == '0));

  always_comb begin
    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    pend_data_d = pend_data_q;
    pend_mask_d = pend_mask_q;

    if (emit_i) act_mask_d = w_act_rem;

    if (w_act_free && w_pend_full) begin
      act_data_d  = pend_data_q;
      act_mask_d  = pend_mask_q;
      pend_mask_d = '0;
    end

    if (fire_i) begin
      if (w_act_free && !w_pend_full) begin
        act_data_d = word_i;
        act_mask_d = mask_i;
      end else begin
        pend_data_d = word_i;
        pend_mask_d = mask_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_data_q  <= '0;
      act_mask_q  <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
    end else begin
      act_data_q  <= act_data_d;
      act_mask_q  <= act_mask_d;
      pend_data_q <= pend_data_d;
      pend_mask_q <= pend_mask_d;
    end
  end

  assign act_data_o  = act_data_q;
  assign act_mask_o  = act_mask_q;
  assign pend_full_o = w_pend_full;
  assign ready_o     = ~w_pend_full;

endmodule
`default_nettype wire

// File: rtl/mux_4x1_8bits.sv
`default_nettype none
// ============================================================================
// mux_4x1_8bits : merges four byte lanes back into one serial byte stream
// Revision 1.0
// ============================================================================
module mux_4x1_8bits
  import mux_4x1_8bits_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  validIn0,
  input  logic                  validIn1,
  input  logic                  validIn2,
  input  logic                  validIn3,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic                  ready,
  output logic                  validOut,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  overflow
);

  logic [LANES-1:0][DATA_WIDTH-1:0] w_word;
  logic [LANES-1:0][DATA_WIDTH-1:0] w_act_data;
  mask_t                            w_mask;
  mask_t                            w_act_mask;
  logic                             w_fire;
  logic                             w_emit;
  logic                             w_ready;
  logic                             w_pend_full;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  validOut_q, validOut_d;
  logic                  overflow_q, overflow_d;

  assign w_mask = {validIn3, validIn2, validIn1, validIn0};
  assign w_word = {data_in3, data_in2, data_in1, data_in0};
  assign w_fire = w_ready & (|w_mask);
  assign w_emit = (state_q == ST_SEND);

  mux_word_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buffer (
    .clk         (clk),
    .reset       (reset),
    .fire_i      (w_fire),
    .word_i      (w_word),
    .mask_i      (w_mask),
    .emit_i      (w_emit),
    .act_data_o  (w_act_data),
    .act_mask_o  (w_act_mask),
    .pend_full_o (w_pend_full),
    .ready_o     (w_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_out_q <= '0;
      validOut_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      validOut_q <= validOut_d;
      overflow_q <= overflow_d;
    end
  end

  // Leave SEND only when the last lane goes out with nothing left to refill ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_fire) state_d = ST_SEND;
      ST_SEND: if (is_last(w_act_mask) && !w_pend_full && !w_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    validOut_d = 1'b0;
    data_out_d = data_out_q;
    if (w_emit) begin
      validOut_d = 1'b1;
      data_out_d = w_act_data[lowest_lane(w_act_mask)];
    end
    overflow_d = overflow_q | ((|w_mask) & ~w_ready);
  end

  assign ready    = w_ready;
  assign validOut = validOut_q;
  assign data_out = data_out_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1_8bits.sv
`default_nettype none
// ============================================================================
// tb_mux_4x1_8bits : self-checking bench with a byte-queue reference model
// Revision 1.0
// ============================================================================
module tb_mux_4x1_8bits;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] vin = 4'h0;
  logic [7:0] din [4];
  logic       ready, validOut, overflow;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes still to be sent, and how many belong to each held word.
  logic [7:0] bq [$];
  int         wq [$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;

  mux_4x1_8bits #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .validIn0 (vin[0]),
    .validIn1 (vin[1]),
    .validIn2 (vin[2]),
    .validIn3 (vin[3]),
    .data_in0 (din[0]),
    .data_in1 (din[1]),
    .data_in2 (din[2]),
    .data_in3 (din[3]),
    .ready    (ready),
    .validOut (validOut),
    .data_out (data_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    bq.delete();
    wq.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then move
  // to just after the edge.
  task automatic tick();
    logic fire;
    int   n;
    fire = (vin != 4'h0) && (wq.size() < 2);
    if ((vin != 4'h0) && (wq.size() >= 2)) m_ovf = 1'b1;
    if (wq.size() > 0) begin
      m_valid = 1'b1;
      m_data  = bq.pop_front();
      wq[0]   = wq[0] - 1;
      if (wq[0] == 0) void'(wq.pop_front());
    end else begin
      m_valid = 1'b0;
    end
    if (fire) begin
      n = 0;
      for (int l = 0; l < 4; l++) begin
        if (vin[l]) begin
          bq.push_back(din[l]);
          n++;
        end
      end
      wq.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vin   = 4'h0;
    for (int l = 0; l < 4; l++) din[l] = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (validOut !== 1'b0) begin bad++; $display("FAIL reset_validOut: got %b want 0", validOut); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tick();
    total++; if (validOut !== 1'b0) begin bad++; $display("FAIL idle_no_fire: validOut got %b want 0", validOut); end
  endtask

  task automatic test_full_word();
    logic [7:0] got [$];
    logic [7:0] want [4];
    logic       exp_rdy;
    want = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_reset();
    vin = 4'hF;
    din = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    tick();
    vin = 4'h0;
    total++; if (validOut !== 1'b0) begin bad++; $display("FAIL full_word_latency: validOut got %b want 0 at fire edge", validOut); end
    for (int c = 0; c < 6; c++) begin
      tick();
      exp_rdy = (wq.size() < 2);
      total++;
      if (validOut !== m_valid || data_out !== m_data || ready !== exp_rdy || overflow !== m_ovf) begin
        bad++;
        $display("FAIL full_word_cyc%0d: got v=%b d=%h r=%b o=%b want v=%b d=%h r=%b o=%b",
                 c, validOut, data_out, ready, overflow, m_valid, m_data, exp_rdy, m_ovf);
      end
      if (c == 0) begin
        total++;
        if (validOut !== 1'b1 || data_out !== 8'hA0) begin
          bad++; $display("FAIL full_word_first: got v=%b d=%h want v=1 d=a0", validOut, data_out);
        end
      end
      if (validOut === 1'b1) got.push_back(data_out);
    end
    total++; if (got.size() != 4) begin bad++; $display("FAIL full_word_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++;
      if (got[i] !== want[i]) begin bad++; $display("FAIL full_word_byte%0d: got %h want %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int   k = 0, nvalid = 0, first = -1, last = -1;
    logic fire_now, saw_low = 1'b0, exp_rdy;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      fire_now = (k < 3) && (ready === 1'b1);
      vin = fire_now ? 4'hF : 4'h0;
      for (int l = 0; l < 4; l++) din[l] = 8'($urandom);
      tick();
      if (fire_now) k++;
      exp_rdy = (wq.size() < 2);
      total++;
      if (validOut !== m_valid || data_out !== m_data || ready !== exp_rdy || overflow !== m_ovf) begin
        bad++;
        $display("FAIL b2b_cyc%0d: got v=%b d=%h r=%b o=%b want v=%b d=%h r=%b o=%b",
                 c, validOut, data_out, ready, overflow, m_valid, m_data, exp_rdy, m_ovf);
      end
      if (ready === 1'b0) saw_low = 1'b1;
      if (validOut === 1'b1) begin
        nvalid++;
        if (first < 0) first = c;
        last = c;
      end
    end
    total++; if (nvalid != 12) begin bad++; $display("FAIL b2b_count: got %0d want 12", nvalid); end
    total++; if (last - first != 11) begin bad++; $display("FAIL b2b_gap: span got %0d want 11", last - first); end
    total++; if (saw_low !== 1'b1) begin bad++; $display("FAIL b2b_ready_drop: got %b want 1", saw_low); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_partial_mask();
    logic [7:0] got [$];
    do_reset();
    vin = 4'b1010;
    din = '{8'h00, 8'h11, 8'h22, 8'h33};
    tick();
    vin = 4'h0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (validOut !== m_valid || data_out !== m_data) begin
        bad++; $display("FAIL partial_cyc%0d: got v=%b d=%h want v=%b d=%h", c, validOut, data_out, m_valid, m_data);
      end
      if (validOut === 1'b1) got.push_back(data_out);
    end
    total++;
    if (got.size() != 2) begin
      bad++; $display("FAIL partial_count: got %0d want 2", got.size());
    end else begin
      total++;
      if (got[0] !== 8'h11 || got[1] !== 8'h33) begin
        bad++; $display("FAIL partial_order: got %h,%h want 11,33", got[0], got[1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic exp_rdy;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      vin = (c < 10) ? 4'hF : 4'h0;
      for (int l = 0; l < 4; l++) din[l] = 8'($urandom);
      tick();
      exp_rdy = (wq.size() < 2);
      total++;
      if (validOut !== m_valid || data_out !== m_data || ready !== exp_rdy || overflow !== m_ovf) begin
        bad++;
        $display("FAIL overflow_cyc%0d: got v=%b d=%h r=%b o=%b want v=%b d=%h r=%b o=%b",
                 c, validOut, data_out, ready, overflow, m_valid, m_data, exp_rdy, m_ovf);
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, cyc = 0;
    do_reset();
    vin = 4'hF;
    din = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    tick();
    vin = 4'h0;
    while (seen < 2 && cyc < 10) begin
      tick();
      if (validOut === 1'b1) seen++;
      cyc++;
    end
    total++; if (seen != 2) begin bad++; $display("FAIL reset_mid_pre: bytes got %0d want 2", seen); end
    reset = 1'b1;
    #1;
    total++;
    if (validOut !== 1'b0 || data_out !== 8'h00 || ready !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_mid_async: got v=%b d=%h r=%b o=%b want v=0 d=00 r=1 o=0",
                      validOut, data_out, ready, overflow);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (validOut !== 1'b0 || data_out !== 8'h00) begin
        bad++; $display("FAIL reset_mid_after%0d: got v=%b d=%h want v=0 d=00", c, validOut, data_out);
      end
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      vin = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) vin = 4'h0;
      for (int l = 0; l < 4; l++) din[l] = 8'($urandom);
      tick();
      exp_rdy = (wq.size() < 2);
      total++;
      if (validOut !== m_valid || data_out !== m_data || ready !== exp_rdy || overflow !== m_ovf) begin
        bad++;
        $display("FAIL random_cyc%0d: got v=%b d=%h r=%b o=%b want v=%b d=%h r=%b o=%b",
                 c, validOut, data_out, ready, overflow, m_valid, m_data, exp_rdy, m_ovf);
      end
    end
  endtask

  // Striper stage: byte k goes to lane k%4, one full word per four bytes.
  task automatic test_loopback();
    logic [7:0] src [$];
    logic [7:0] got [$];
    int         widx = 0, cyc = 0;
    logic       fire_now;
    do_reset();
    for (int i = 0; i < 32; i++) src.push_back(8'(i));
    while (got.size() < 32 && cyc < 200) begin
      fire_now = (widx < 8) && (ready === 1'b1);
      vin = fire_now ? 4'hF : 4'h0;
      if (fire_now) for (int l = 0; l < 4; l++) din[l] = src[widx * 4 + l];
      tick();
      if (fire_now) widx++;
      if (validOut === 1'b1) got.push_back(data_out);
      cyc++;
    end
    total++; if (got.size() != 32) begin bad++; $display("FAIL loopback_count: got %0d want 32", got.size()); end
    for (int i = 0; i < 32 && i < got.size(); i++) begin
      total++;
      if (got[i] !== src[i]) begin bad++; $display("FAIL loopback_byte%0d: got %h want %h", i, got[i], src[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_partial_mask();
    test_overflow();
    test_reset_mid();
    test_random();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
